// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit saturating counters and retire statistics
module branch_predictor #(
  parameter int IDX_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] iIfPc,
  input  logic        iIfValid,
  input  logic        iStall,
  input  logic        iFlush,
  input  logic        iUpdValid,
  input  logic [15:0] iUpdPc,
  input  logic        iUpdTaken,
  input  logic [15:0] iUpdTarget,
  input  logic        iUpdMispredict,
  output logic        oPredTaken,
  output logic [15:0] oPredTarget,
  output logic [15:0] oBranchCount,
  output logic [15:0] oMispredCount
);
  localparam int N  = 1 << IDX_W;
  localparam int TW = 15 - IDX_W;
  logic [N-1:0]     valid;
  logic [TW-1:0]    tags    [N];
  logic [15:0]      targets [N];
  logic [1:0]       ctrs    [N];
  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TW-1:0]    l_tag, u_tag;
  logic             l_taken, u_hit;
  logic [1:0]       u_ctr;
  // lookup and update decode against the current (pre-write) table contents
  always_comb begin
    l_idx   = iIfPc[IDX_W:1];
    l_tag   = iIfPc[15:IDX_W+1];
    l_taken = iIfValid && valid[l_idx] && (tags[l_idx] == l_tag) && ctrs[l_idx][1];
    u_idx   = iUpdPc[IDX_W:1];
    u_tag   = iUpdPc[15:IDX_W+1];
    u_hit   = valid[u_idx] && (tags[u_idx] == u_tag);
    u_ctr   = iUpdTaken ? ((ctrs[u_idx] == 2'b11) ? 2'b11 : ctrs[u_idx] + 2'd1)
                        : ((ctrs[u_idx] == 2'b00) ? 2'b00 : ctrs[u_idx] - 2'd1);
  end
  // table training: hits move the counter, taken misses allocate in weak-taken
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      for (int i = 0; i < N; i++) ctrs[i] <= 2'b00;
    end else if (iUpdValid) begin
      if (u_hit) begin
        ctrs[u_idx] <= u_ctr;
        if (iUpdTaken) targets[u_idx] <= iUpdTarget;
      end else if (iUpdTaken) begin
        valid[u_idx]   <= 1'b1;
        tags[u_idx]    <= u_tag;
        targets[u_idx] <= iUpdTarget;
        ctrs[u_idx]    <= 2'b10;
      end
    end
  end
  // ID-aligned prediction register; flush beats stall
  always_ff @(posedge clk) begin
    if (reset || iFlush) begin
      oPredTaken  <= 1'b0;
      oPredTarget <= 16'h0000;
    end else if (!iStall) begin
      oPredTaken  <= l_taken;
      oPredTarget <= l_taken ? targets[l_idx] : 16'h0000;
    end
  end
  // saturating retire statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      oBranchCount  <= 16'h0000;
      oMispredCount <= 16'h0000;
    end else begin
      oBranchCount  <= oBranchCount + {15'd0, iUpdValid && (oBranchCount != 16'hFFFF)};
      oMispredCount <= oMispredCount + {15'd0, iUpdValid && iUpdMispredict && (oMispredCount != 16'hFFFF)};
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vector table, random traffic against a reference model, counter saturation
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        reset, iIfValid, iStall, iFlush, iUpdValid, iUpdTaken, iUpdMispredict;
  logic [15:0] iIfPc, iUpdPc, iUpdTarget;
  logic        oPredTaken;
  logic [15:0] oPredTarget, oBranchCount, oMispredCount;

  branch_predictor dut (
    .clk(clk), .reset(reset), .iIfPc(iIfPc), .iIfValid(iIfValid), .iStall(iStall),
    .iFlush(iFlush), .iUpdValid(iUpdValid), .iUpdPc(iUpdPc), .iUpdTaken(iUpdTaken),
    .iUpdTarget(iUpdTarget), .iUpdMispredict(iUpdMispredict), .oPredTaken(oPredTaken),
    .oPredTarget(oPredTarget), .oBranchCount(oBranchCount), .oMispredCount(oMispredCount)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model: 16 entries, counter as an integer strength 0..3
  typedef struct {
    bit v;
    int tag;
    int tgt;
    int ctr;
  } ent_t;
  ent_t m[16];
  int   m_pred, m_tgt, m_bc, m_mc;

  function automatic void model_edge();
    int li, lt, ui, ut, newp;
    bit hit;
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        m[i].v = 0;
        m[i].ctr = 0;
      end
      m_pred = 0; m_tgt = 0; m_bc = 0; m_mc = 0;
      return;
    end
    li = (int'(iIfPc) >> 1) % 16;
    lt = int'(iIfPc) >> 5;
    newp = (iIfValid && m[li].v && m[li].tag == lt && m[li].ctr >= 2) ? 1 : 0;
    if (iFlush) begin
      m_pred = 0; m_tgt = 0;
    end else if (!iStall) begin
      m_pred = newp;
      m_tgt = newp ? m[li].tgt : 0;
    end
    if (iUpdValid) begin
      if (m_bc < 65535) m_bc++;
      if (iUpdMispredict && m_mc < 65535) m_mc++;
      ui = (int'(iUpdPc) >> 1) % 16;
      ut = int'(iUpdPc) >> 5;
      hit = m[ui].v && m[ui].tag == ut;
      if (hit) begin
        if (iUpdTaken) begin
          if (m[ui].ctr < 3) m[ui].ctr++;
          m[ui].tgt = int'(iUpdTarget);
        end else if (m[ui].ctr > 0) m[ui].ctr--;
      end else if (iUpdTaken) begin
        m[ui].v = 1; m[ui].tag = ut; m[ui].tgt = int'(iUpdTarget); m[ui].ctr = 2;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    reset = 0; iIfPc = 0; iIfValid = 0; iStall = 0; iFlush = 0;
    iUpdValid = 0; iUpdPc = 0; iUpdTaken = 0; iUpdTarget = 0; iUpdMispredict = 0;
  endtask

  typedef struct {
    bit          rst;
    logic [15:0] pc;
    bit          ifv, stall, flush, uv;
    logic [15:0] upc;
    bit          ut;
    logic [15:0] utgt;
    bit          ep;
    logic [15:0] et;
  } vec_t;
  vec_t vq[$];

  initial begin
    //             rst pc       ifv st fl uv upc      ut utgt     ep et
    vq.push_back('{1, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000});
    vq.push_back('{0, 16'h3000, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000});
    vq.push_back('{0, 16'h0000, 0, 0, 0, 1, 16'h3000, 1, 16'h3040, 0, 16'h0000});
    vq.push_back('{0, 16'h3000, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h3040});
    vq.push_back('{0, 16'h3000, 1, 0, 0, 1, 16'h3000, 0, 16'h0000, 1, 16'h3040});
    vq.push_back('{0, 16'h3000, 1, 0, 0, 1, 16'h3000, 0, 16'h0000, 0, 16'h0000});
    vq.push_back('{0, 16'h3000, 1, 0, 0, 1, 16'h3000, 0, 16'h0000, 0, 16'h0000});
    vq.push_back('{0, 16'h0000, 0, 0, 0, 1, 16'h3000, 1, 16'h3040, 0, 16'h0000});
    vq.push_back('{0, 16'h3000, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000});
    vq.push_back('{0, 16'h0000, 0, 0, 0, 1, 16'h3000, 1, 16'h3040, 0, 16'h0000});
    vq.push_back('{0, 16'h3020, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000});
    vq.push_back('{0, 16'h0000, 0, 0, 0, 1, 16'h3020, 1, 16'h3100, 0, 16'h0000});
    vq.push_back('{0, 16'h3000, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000});
    vq.push_back('{0, 16'h3020, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h3100});
    vq.push_back('{0, 16'h3000, 1, 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h3100});
    vq.push_back('{0, 16'h3000, 1, 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h3100});
    vq.push_back('{0, 16'h3000, 1, 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h3100});
    vq.push_back('{0, 16'h3020, 1, 1, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000});
    vq.push_back('{0, 16'h3020, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h3100});
    vq.push_back('{0, 16'h3020, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000});
    vq.push_back('{0, 16'h3020, 1, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000});
    vq.push_back('{1, 16'h3020, 1, 0, 0, 1, 16'h3020, 1, 16'h3100, 0, 16'h0000});
    vq.push_back('{0, 16'h3020, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000});

    idle();
    reset = 1;
    tick();
    chk("reset_branch_count", int'(oBranchCount), 0);
    chk("reset_mispred_count", int'(oMispredCount), 0);

    foreach (vq[i]) begin
      reset = vq[i].rst; iIfPc = vq[i].pc; iIfValid = vq[i].ifv; iStall = vq[i].stall;
      iFlush = vq[i].flush; iUpdValid = vq[i].uv; iUpdPc = vq[i].upc;
      iUpdTaken = vq[i].ut; iUpdTarget = vq[i].utgt; iUpdMispredict = 0;
      tick();
      chk($sformatf("vec%0d_taken", i), int'(oPredTaken), int'(vq[i].ep));
      chk($sformatf("vec%0d_target", i), int'(oPredTarget), int'(vq[i].et));
      chk($sformatf("vec%0d_branch_count", i), int'(oBranchCount), m_bc);
    end

    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      iIfPc = 16'h3000 | 16'($urandom_range(0, 3) << 5) | 16'($urandom_range(0, 3) << 1) | 16'($urandom_range(0, 1));
      iIfValid = ($urandom_range(0, 3) != 0);
      iStall = ($urandom_range(0, 4) == 0);
      iFlush = ($urandom_range(0, 9) == 0);
      iUpdValid = ($urandom_range(0, 1) == 1);
      iUpdPc = 16'h3000 | 16'($urandom_range(0, 3) << 5) | 16'($urandom_range(0, 3) << 1);
      iUpdTaken = ($urandom_range(0, 2) != 0);
      iUpdTarget = 16'($urandom);
      iUpdMispredict = ($urandom_range(0, 1) == 1);
      tick();
      chk("rand_taken", int'(oPredTaken), m_pred);
      chk("rand_target", int'(oPredTarget), m_tgt);
      chk("rand_branch_count", int'(oBranchCount), m_bc);
      chk("rand_mispred_count", int'(oMispredCount), m_mc);
    end

    idle();
    reset = 1;
    tick();
    reset = 0; iUpdValid = 1; iUpdMispredict = 1; iUpdTaken = 0; iUpdPc = 16'h5554;
    for (int n = 0; n < 65537; n++) tick();
    chk("sat_branch_count", int'(oBranchCount), 16'hFFFF);
    chk("sat_mispred_count", int'(oMispredCount), 16'hFFFF);
    chk("sat_model_branch", int'(oBranchCount), m_bc);
    idle();
    reset = 1;
    tick();
    chk("post_sat_reset_branch", int'(oBranchCount), 0);
    chk("post_sat_reset_mispred", int'(oMispredCount), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter IDX_W, default 4, meaning the table holds 2**IDX_W entries indexed by PC[IDX_W:1].
REQ-002 SHALL have tag = PC[15:IDX_W+1] (11 bits at default); each entry holds valid, tag, target[15:0] and a 2-bit counter.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 iIfPc  in  16  fetch-stage PC for lookup.
REQ-007 iIfValid  in  1  iIfPc is a real fetch this cycle.
REQ-008 iStall  in  1  ID-stage hold; prediction registers keep their value.
REQ-009 iFlush  in  1  pipeline redirect; discards the in-flight prediction.
REQ-010 iUpdValid  in  1  WB is retiring a conditional branch this cycle.
REQ-011 iUpdPc  in  16  PC of the retiring branch.
REQ-012 iUpdTaken  in  1  resolved direction (NZP match) of the retiring branch.
REQ-013 iUpdTarget  in  16  resolved branch target.
REQ-014 iUpdMispredict  in  1  WB-stage misprediction flag for the retiring branch.
REQ-015 oPredTaken  out  1  registered taken prediction, aligned with ID stage.
REQ-016 oPredTarget  out  16  registered predicted target, aligned with ID stage.
REQ-017 oBranchCount  out  16  count of retired conditional branches.
REQ-018 oMispredCount  out  16  count of retired mispredicted branches.

Function
REQ-019 Lookup hit SHALL mean entry[idx(iIfPc)] is valid and its tag equals tag(iIfPc).
REQ-020 Latency SHALL be 1 cycle: on a clock edge with iStall=0 and iFlush=0, oPredTaken <= iIfValid & hit & counter[1].
REQ-021 On the same edge, oPredTarget <= entry target when the new oPredTaken is 1, else 16'h0000.
REQ-022 With iStall=1 and iFlush=0, oPredTaken and oPredTarget SHALL hold their values.
REQ-023 On iFlush=1, oPredTaken and oPredTarget SHALL be cleared to 0 on the next edge; iFlush overrides iStall.
REQ-024 Counter encoding SHALL be 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-025 An update hit (valid and tag match at idx(iUpdPc)) SHALL increment the counter when iUpdTaken=1 and decrement it when iUpdTaken=0.
REQ-026 Counter updates SHALL saturate: 11 stays 11 on taken; 00 stays 00 on not-taken.
REQ-027 On an update hit with iUpdTaken=1, the entry target SHALL be overwritten with iUpdTarget.
REQ-028 On an update miss with iUpdTaken=1, the entry SHALL be allocated: valid=1, tag=tag(iUpdPc), target=iUpdTarget, counter=10. Any previous occupant is replaced.
REQ-029 On an update miss with iUpdTaken=0, the table SHALL be left unchanged.
REQ-030 Table writes SHALL take effect at the clock edge on which iUpdValid=1, regardless of iStall and iFlush.
REQ-031 Same-cycle lookup and update to the same index SHALL be read-before-write: the lookup sees pre-update contents.
REQ-032 oBranchCount SHALL increment on each edge with iUpdValid=1, saturating at 16'hFFFF.
REQ-033 oMispredCount SHALL increment on each edge with iUpdValid=1 and iUpdMispredict=1, saturating at 16'hFFFF.
REQ-034 iUpdMispredict and iUpdTaken SHALL be ignored when iUpdValid=0.

Reset
REQ-035 On reset=1 at an edge, all valid bits, counters, oPredTaken, oPredTarget, oBranchCount and oMispredCount SHALL go to 0, overriding any concurrent update, stall or flush.
REQ-036 Reset asserted mid-operation SHALL discard all learned state; the first lookup after reset SHALL predict not-taken.

Verification
REQ-037 After reset, lookup with iIfPc=16'h3000, iIfValid=1 -> next cycle oPredTaken=0, oPredTarget=16'h0000.
REQ-038 Update iUpdPc=16'h3000, iUpdTaken=1, iUpdTarget=16'h3040, then lookup 16'h3000 -> oPredTaken=1, oPredTarget=16'h3040 (counter=10).
REQ-039 Same entry, apply two not-taken updates -> counter 10->01->00; lookup -> oPredTaken=0; a third not-taken update leaves the counter at 00.
REQ-040 Entry allocated for 16'h3000; look up 16'h3020 (same index, different tag) -> oPredTaken=0; taken update at 16'h3020 replaces the entry, after which lookup of 16'h3000 misses.
REQ-041 Hold oPredTaken=1 with iStall=1 for 3 cycles -> output stable; assert iStall=1 and iFlush=1 together -> next cycle oPredTaken=0.
REQ-042 Drive 16'hFFFF+2 updates with iUpdMispredict=1 -> both counters read 16'hFFFF; then reset -> both read 0.
